// File: rtl/sram_march_tester.sv
// sram_march_tester: march-style write/read-compare tester driving the sram controller request side
module sram_march_tester #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 16,
  parameter int unsigned LAST_ADDR = 2**18-1,
  parameter logic [DATA_WIDTH-1:0] PATTERN = 16'hAAAA
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  ready,
  input  logic [DATA_WIDTH-1:0] data_read,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] data_write,
  output logic                  write,
  output logic                  read,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic [3:0]            status
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(LAST_ADDR);
  state_t state_q, state_d;
  logic guard_q, guard_d;
  logic [1:0] phase_q, phase_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, fail_addr_q, fail_addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d, fail_data_q, fail_data_d;
  logic done_q, done_d, pass_q, pass_d;
  function automatic logic [DATA_WIDTH-1:0] pat(input logic [ADDR_WIDTH-1:0] a, input logic [1:0] p);
    return {DATA_WIDTH{p[1]}} ^ PATTERN ^ DATA_WIDTH'(a);
  endfunction
  always_comb begin
    state_d = state_q;
    guard_d = state_q == ISSUE;
    phase_d = phase_q;
    addr_d = addr_q;
    data_d = data_q;
    done_d = done_q;
    pass_d = pass_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    write = 1'b0;
    read = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = ISSUE;
        phase_d = '0;
        addr_d = '0;
        data_d = PATTERN;
        done_d = 1'b0;
        pass_d = 1'b1;
        fail_addr_d = '0;
        fail_data_d = '0;
      end
      ISSUE: if (ready) begin
        write = ~phase_q[0];
        read = phase_q[0];
        state_d = WAIT;
      end
      WAIT: if (!guard_q && ready) begin
        if (phase_q[0] && data_read != data_q) begin
          pass_d = 1'b0;
          fail_addr_d = addr_q;
          fail_data_d = data_read;
          done_d = 1'b1;
          state_d = DONE;
        end else if (addr_q == LAST && phase_q == 2'd3) begin
          done_d = 1'b1;
          state_d = DONE;
        end else begin
          addr_d = addr_q == LAST ? '0 : addr_q + 1'b1;
          phase_d = addr_q == LAST ? phase_q + 2'd1 : phase_q;
          data_d = pat(addr_d, phase_d);
          state_d = ISSUE;
        end
      end
      default: if (!start) state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      guard_q <= 1'b0;
      phase_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      state_q <= state_d;
      guard_q <= guard_d;
      phase_q <= phase_d;
      addr_q <= addr_d;
      data_q <= data_d;
      done_q <= done_d;
      pass_q <= pass_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
    end
  end
  assign address = addr_q;
  assign data_write = data_q;
  assign busy = state_q == ISSUE || state_q == WAIT;
  assign done = done_q;
  assign pass = pass_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign status = {done_q, pass_q, phase_q};
endmodule

// File: tb/tb_sram_march_tester.sv
// tb_sram_march_tester: table-driven runs against a behavioural controller+SRAM with injectable stuck bits
module tb_sram_march_tester;
  logic clk = 1'b0;
  logic reset_n, start, hold;
  logic ready, write, read, busy, done, pass;
  logic [15:0] data_read = '0, data_write, fail_data;
  logic [17:0] address, fail_addr;
  logic [3:0] status;
  logic [15:0] fmask, fval;
  logic [2:0] faddr;
  logic [15:0] mem [8];
  int cnt = 0, nreq = 0;
  int checks = 0, errors = 0, mchecks = 0, merrors = 0;
  int seq = 0;
  logic busy_p = 1'b0, pulse_p = 1'b0;

  sram_march_tester #(.LAST_ADDR(7)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ready(ready), .data_read(data_read),
    .address(address), .data_write(data_write), .write(write), .read(read), .busy(busy),
    .done(done), .pass(pass), .fail_addr(fail_addr), .fail_data(fail_data), .status(status)
  );

  always #5 clk = ~clk;

  assign ready = cnt == 0 && !hold;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt <= 0;
    else if (write || read) begin
      cnt <= 2;
      nreq <= nreq + 1;
      if (write) mem[address[2:0]] <= data_write;
      else data_read <= address[2:0] == faddr ? (mem[address[2:0]] & ~fmask) | (fval & fmask) : mem[address[2:0]];
    end else if (cnt > 0) cnt <= cnt - 1;
  end

  function automatic logic [15:0] exp_data(input int k);
    logic [15:0] d;
    d = 16'hAAAA ^ 16'(k % 8);
    return ((k / 8) >= 2) ? ~d : d;
  endfunction

  always @(negedge clk) begin
    if (!busy_p && busy) seq = 0;
    busy_p = busy;
    if (write || read) begin
      mchecks++;
      if ((write && read) || !ready || pulse_p || address != 18'(seq % 8) || write != (((seq / 8) % 2) == 0) || seq > 31 ||
          (write && data_write != exp_data(seq))) begin
        merrors++;
        $display("FAIL req%0d: write=%b read=%b ready=%b prev_pulse=%b addr=%0d data=%h, required write=%0d addr=%0d data=%h",
                 seq, write, read, ready, pulse_p, address, data_write, ((seq / 8) % 2) == 0, seq % 8, exp_data(seq));
      end
      seq++;
    end
    pulse_p = write || read;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    @(negedge clk);
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_timeout"}, done, 1'b1);
  endtask

  typedef struct {
    logic [15:0] fmask;
    logic [15:0] fval;
    logic [2:0]  faddr;
    logic        exp_pass;
    logic [17:0] exp_fa;
    logic [15:0] exp_fd;
    int          exp_reqs;
    logic [3:0]  exp_status;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int base;
    int pulses;
    vecs[0] = '{16'h0000, 16'h0000, 3'd0, 1'b1, 18'd0, 16'h0000, 32, 4'hF};
    vecs[1] = '{16'h0001, 16'h0001, 3'd5, 1'b0, 18'd5, 16'h5551, 30, 4'hB};
    vecs[2] = '{16'h0001, 16'h0000, 3'd5, 1'b0, 18'd5, 16'hAAAE, 14, 4'h9};
    vecs[3] = '{16'h8000, 16'h8000, 3'd2, 1'b0, 18'd2, 16'hD557, 27, 4'hB};
    vecs[4] = '{16'h0002, 16'h0000, 3'd7, 1'b0, 18'd7, 16'h5550, 32, 4'hB};
    vecs[5] = '{16'h0002, 16'h0002, 3'd0, 1'b0, 18'd0, 16'h5557, 25, 4'hB};
    reset_n = 1'b0; start = 1'b0; hold = 1'b0;
    fmask = '0; fval = '0; faddr = '0;
    #12;
    chk("reset_ctl", {write, read, busy, done, pass, status}, '0);
    chk("reset_addr", address, '0);
    chk("reset_fail", {fail_addr, fail_data}, '0);
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);

    for (int i = 0; i < 6; i++) begin
      fmask = vecs[i].fmask; fval = vecs[i].fval; faddr = vecs[i].faddr;
      base = nreq;
      start = 1'b1;
      wait_done($sformatf("v%0d", i));
      chk($sformatf("v%0d_pass", i), pass, vecs[i].exp_pass);
      chk($sformatf("v%0d_fail_addr", i), fail_addr, vecs[i].exp_fa);
      chk($sformatf("v%0d_fail_data", i), fail_data, vecs[i].exp_fd);
      chk($sformatf("v%0d_status", i), status, vecs[i].exp_status);
      chk($sformatf("v%0d_busy", i), busy, 1'b0);
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_reqs", i), nreq - base, vecs[i].exp_reqs);
      chk($sformatf("v%0d_done_held", i), done, 1'b1);
    end
    fmask = '0; fval = '0;

    hold = 1'b1;
    base = nreq;
    start = 1'b1;
    @(negedge clk);
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      pulses += int'(write || read);
    end
    chk("bp_no_pulse", pulses, 0);
    chk("bp_busy", {busy, status[1:0], address}, {1'b1, 2'd0, 18'd0});
    hold = 1'b0;
    #1;
    chk("bp_release_write", {write, read}, 2'b10);
    wait_done("bp");
    chk("bp_pass", pass, 1'b1);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("bp_reqs", nreq - base, 32);

    start = 1'b1;
    pulses = 0;
    @(negedge clk);
    while (!(status[1:0] == 2'd2 && address == 18'd3) && pulses < 2000) begin
      @(negedge clk);
      pulses++;
    end
    chk("mr_reached", {busy, status[1:0], address}, {1'b1, 2'd2, 18'd3});
    #2 reset_n = 1'b0;
    #1;
    chk("mr_ctl", {write, read, busy, done, pass, status}, '0);
    chk("mr_addr_data", {address, data_write}, '0);
    chk("mr_fail", {fail_addr, fail_data}, '0);
    base = nreq;
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
    chk("mr_restart", {busy, status[1:0], address, data_write}, {1'b1, 2'd0, 18'd0, 16'hAAAA});
    wait_done("mr");
    chk("mr_pass", {pass, status}, {1'b1, 4'hF});
    chk("mr_reqs", nreq - base, 32);

    repeat (10) @(negedge clk);
    chk("rt_no_rerun", nreq - base, 32);
    chk("rt_state", {busy, done}, 2'b01);
    start = 1'b0;
    repeat (2) @(negedge clk);
    base = nreq;
    start = 1'b1;
    wait_done("rt");
    chk("rt_pass", pass, 1'b1);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rt_reqs", nreq - base, 32);

    $display("Simulation finished: %0d checks, %0d errors", checks + mchecks, errors + merrors);
    $finish;
  end
endmodule
